// File: rtl/ifu_prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch front end.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ifu_prefetch_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Generic circular FIFO with occupancy count; storage array carries no reset.
// Latency: a pushed entry is visible at the head the next cycle, no bypass.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module prefetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output T                       head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == DEPTH_W);
    assign empty    = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: pipelined req/gnt/rvalid fetch into an in-order buffer, with flush/redirect.
// Latency: a response shows on inst_valid_o one cycle after rvalid; requests are registered (one cycle after credit frees).
// Backpressure: inst_ready_i low fills the buffer; requests stop once buffered + in-flight entries reach DEPTH.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic          stale_q, stale_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;

    logic          granted, drop, can_issue;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt, cnt_d;
    fetch_entry_t  push_ent, head_ent;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush_i),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .head_dat (head_ent),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        granted      = req_q && instr_gnt_i;
        drop         = instr_rvalid_i && (disc_q != '0);
        fifo_push    = instr_rvalid_i && !drop && !flush_i;
        fifo_pop     = !fifo_empty && inst_ready_i && !flush_i;
        push_ent     = '0;
        push_ent.inst = instr_rdata_i;
        push_ent.pc   = resp_pc_q;
        push_ent.err  = instr_err_i;

        out_d = out_q;
        if (granted && !instr_rvalid_i)      out_d = out_q + CW'(1);
        else if (!granted && instr_rvalid_i) out_d = out_q - CW'(1);

        disc_d     = drop ? disc_q - CW'(1) : disc_q;
        stale_d    = stale_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        state_d    = state_q;

        // A request issued before a redirect still returns data from the old stream.
        if (granted) begin
            if (stale_q) begin
                disc_d  = disc_d + CW'(1);
                stale_d = 1'b0;
            end else begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end

        if (fifo_push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
            if (instr_err_i) state_d = HALT;
        end

        if (flush_i) begin
            fetch_pc_d = word_align(flush_addr_i);
            resp_pc_d  = word_align(flush_addr_i);
            state_d    = FETCH;
            disc_d     = out_d;
            stale_d    = req_q && !instr_gnt_i;
        end

        cnt_d = flush_i ? '0 : fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);

        // Credit counts granted-but-unreturned requests against free buffer space.
        can_issue = (state_d == FETCH)
                 && (out_d < MAX_OUT_W)
                 && (({1'b0, cnt_d} + {1'b0, out_d}) < DEPTH_W);

        if (req_q && !instr_gnt_i) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = can_issue;
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            out_q      <= '0;
            disc_q     <= '0;
            stale_q    <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            stale_q    <= stale_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    assign instr_req_o  = req_q;
    assign instr_addr_o = addr_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = inst_valid_o ? head_ent.inst : '0;
    assign pc_o         = inst_valid_o ? head_ent.pc   : '0;
    assign inst_err_o   = inst_valid_o && head_ent.err;

    a_no_rvalid_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(instr_rvalid_i && fifo_full));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus randomized bus/consumer traffic
// checked against an epoch-tagged transaction model of the fetch stream.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o, pc_o;
    logic        inst_err_o;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_err_i = 1'b0;

    ifu_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .pc_o(pc_o), .inst_err_o(inst_err_o), .instr_req_o(instr_req_o),
        .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        logic        err;
    } txn_t;

    txn_t         inflight[$];
    fetch_entry_t exp_q[$];
    int n_assert = 0, n_fail = 0;
    int cyc = 0, epoch = 0, pops = 0, grants = 0, new_reqs = 0, pend_epoch = 0;
    logic [31:0] exp_addr = RESET_PC, pend_addr = '0, last_new_addr = '0;
    bit pend = 0, halted = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100, err_pct = 0;
    bit gnt_block_en = 0, err_addr_en = 0;
    logic [31:0] gnt_block = '0, err_addr = '0;
    logic obs_req, obs_vld, obs_err;
    logic [31:0] obs_addr, obs_inst, obs_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample at negedge, drive inputs, advance the model to the next posedge.
    task automatic tick(input bit fl, input logic [31:0] fa);
        txn_t t;
        fetch_entry_t h;
        bit g, rv, rd;
        @(negedge clk);
        obs_req = instr_req_o;  obs_addr = instr_addr_o;
        obs_vld = inst_valid_o; obs_inst = inst_o; obs_pc = pc_o; obs_err = inst_err_o;

        chk("valid", 32'(obs_vld), 32'(exp_q.size() != 0));
        if (obs_vld && exp_q.size() > 0) begin
            chk("head_inst", obs_inst, exp_q[0].inst);
            chk("head_pc", obs_pc, exp_q[0].pc);
            chk("head_err", 32'(obs_err), 32'(exp_q[0].err));
        end
        if (pend) begin
            chk("req_held", 32'(obs_req), 32'd1);
            chk("addr_held", obs_addr, pend_addr);
        end else if (obs_req) begin
            new_reqs++;
            last_new_addr = obs_addr;
            pend_addr     = obs_addr;
            pend_epoch    = epoch;
            chk("req_addr", obs_addr, exp_addr);
            chk("req_in_halt", 32'(halted), 32'd0);
        end

        g  = obs_req && !(gnt_block_en && obs_addr == gnt_block) && ($urandom_range(99) < gnt_pct);
        rv = inflight.size() > 0 && inflight[0].due <= cyc;
        rd = $urandom_range(99) < rdy_pct;
        instr_gnt_i    = g;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? data_of(inflight[0].addr) : $urandom;
        instr_err_i    = rv ? inflight[0].err : 1'b0;
        inst_ready_i   = rd;
        flush_i        = fl;
        flush_addr_i   = fa;

        if (fl) begin
            epoch++;
            exp_q.delete();
            exp_addr = {fa[31:2], 2'b00};
            halted = 0;
        end else if (obs_vld && rd && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            pops++;
        end
        if (rv) begin
            t = inflight.pop_front();
            if (t.epoch == epoch) begin
                h.inst = data_of(t.addr);
                h.pc   = t.addr;
                h.err  = t.err;
                exp_q.push_back(h);
                if (t.err) halted = 1;
            end
        end
        if (g) begin
            grants++;
            t.addr  = obs_addr;
            t.epoch = pend_epoch;
            t.due   = cyc + int'($urandom_range(lat_max, lat_min));
            t.err   = (err_addr_en && obs_addr == err_addr) || ($urandom_range(99) < err_pct);
            inflight.push_back(t);
            if (pend_epoch == epoch) exp_addr = exp_addr + 32'd4;
        end
        pend = obs_req && !g;
        chk("credit_out", 32'(inflight.size() <= MAXO), 32'd1);
        chk("credit_depth", 32'(inflight.size() + exp_q.size() <= DEPTH), 32'd1);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        inst_ready_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_err", 32'(inst_err_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_addr", instr_addr_o, RESET_PC);
        rst_n = 1'b1;
        inflight.delete(); exp_q.delete();
        epoch++; exp_addr = RESET_PC; halted = 0; pend = 0;
    endtask

    initial begin
        int k, g0, n0;
        bit fl;
        logic [31:0] fa;

        // Back-to-back fetch, single-cycle response
        do_reset();
        tick(0, '0); chk("t1_req", 32'(obs_req), 32'd1); chk("t1_addr0", obs_addr, 32'h0);
        tick(0, '0); chk("t1_addr4", obs_addr, 32'h4);
        tick(0, '0); chk("t1_addr8", obs_addr, 32'h8);
        chk("t1_vld_c3", 32'(obs_vld), 32'd1); chk("t1_pc0", obs_pc, 32'h0);
        tick(0, '0); chk("t1_pc4", obs_pc, 32'h4);
        tick(0, '0); chk("t1_pc8", obs_pc, 32'h8);

        // Consumer stalled: buffer plus in-flight limited to DEPTH
        rdy_pct = 0;
        do_reset();
        g0 = grants;
        repeat (12) tick(0, '0);
        chk("t2_grants", grants - g0, 32'd4);
        chk("t2_idle", 32'(obs_req), 32'd0);
        rdy_pct = 100; tick(0, '0);
        rdy_pct = 0;   tick(0, '0);
        chk("t2_reissue", 32'(obs_req), 32'd1);
        chk("t2_addr10", obs_addr, 32'h10);

        // Flush with two responses in flight
        rdy_pct = 100; lat_min = 4; lat_max = 4;
        do_reset();
        k = 0;
        while (!(inflight.size() == 2 && inflight[0].addr == 32'h20 && inflight[1].addr == 32'h24) && k < 60) begin
            tick(0, '0); k++;
        end
        chk("t3_setup", 32'(k < 60), 32'd1);
        tick(1, 32'h103);
        n0 = new_reqs; k = 0;
        while (new_reqs == n0 && k < 30) begin tick(0, '0); k++; end
        chk("t3_new_addr", last_new_addr, 32'h100);
        k = 0;
        while (!obs_vld && k < 30) begin tick(0, '0); k++; end
        chk("t3_first_pc", obs_pc, 32'h100);

        // Flush while a request waits for grant
        lat_min = 1; lat_max = 1; gnt_block = 32'h8; gnt_block_en = 1;
        do_reset();
        k = 0;
        while (!(obs_req && obs_addr == 32'h8 && pend) && k < 20) begin tick(0, '0); k++; end
        chk("t4_setup", 32'(k < 20), 32'd1);
        tick(1, 32'h40);
        tick(0, '0); chk("t4_hold_req", 32'(obs_req), 32'd1); chk("t4_hold_addr", obs_addr, 32'h8);
        tick(0, '0); chk("t4_hold_addr2", obs_addr, 32'h8);
        gnt_block_en = 0;
        n0 = new_reqs; k = 0;
        while (new_reqs == n0 && k < 30) begin tick(0, '0); k++; end
        chk("t4_new_addr", last_new_addr, 32'h40);
        k = 0;
        while (!obs_vld && k < 30) begin tick(0, '0); k++; end
        chk("t4_first_pc", obs_pc, 32'h40);

        // Bus error halts fetching until a flush
        err_addr = 32'hC; err_addr_en = 1;
        do_reset();
        k = 0;
        while (!(obs_vld && obs_pc == 32'hC) && k < 30) begin tick(0, '0); k++; end
        chk("t5_err_pc", obs_pc, 32'hC);
        chk("t5_err_flag", 32'(obs_err), 32'd1);
        err_addr_en = 0;
        repeat (10) tick(0, '0);
        chk("t5_halted", 32'(obs_req), 32'd0);
        tick(1, 32'h80);
        n0 = new_reqs; k = 0;
        while (new_reqs == n0 && k < 30) begin tick(0, '0); k++; end
        chk("t5_resume", last_new_addr, 32'h80);

        // Reset with responses in flight and a partly full buffer
        rdy_pct = 0; lat_min = 2; lat_max = 2;
        do_reset();
        k = 0;
        while (!(inflight.size() >= 1 && exp_q.size() >= 2) && k < 20) begin tick(0, '0); k++; end
        chk("t6_setup", 32'(k < 20), 32'd1);
        do_reset();
        tick(0, '0);
        chk("t6_restart_req", 32'(obs_req), 32'd1);
        chk("t6_restart_addr", obs_addr, RESET_PC);

        // Randomized traffic with flushes, errors and occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            gnt_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
            lat_min = 1;
            lat_max = $urandom_range(5, 1);
            err_pct = $urandom_range(4, 0);
            if (seg % 10 == 9) do_reset();
            for (int i = 0; i < 80; i++) begin
                fl = ($urandom_range(99) < 5) || (halted && $urandom_range(99) < 20);
                fa = ($urandom_range(9) == 0) ? 32'hFFFF_FFF5 : $urandom;
                tick(fl, fa);
            end
        end
        chk("pops_made", 32'(pops > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
